instr_fetch_decode: RTL and testbench
=====================================

Name: instr_fetch_decode

Overview:
- Instruction fetch/decode front end that feeds the control-pulse sequencer: supplies opcode, qc and extracode, and consumes the sequencer's ext_flag and INDEX requests.
- Fetches the word at the current PC from memory over a req/ack handshake and latches it in an instruction register.
- Applies a pending INDEX modification, then presents decoded fields under a valid/taken handshake.

Parameters:
- WORD_W, 16, memory word width; bit 15 is parity and is carried through unmodified; bits 14:0 are data.
- ADDR_W, 12, PC, memory address and operand address width.
- ACK_TIMEOUT, 15, maximum cycles mem_ack may take before the fetch is aborted; range 1..255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc  in  ADDR_W  address of the next instruction; sampled on an accepted fetch_start.
- fetch_start  in  1  one-cycle request to fetch and decode the instruction at pc.
- ext_flag  in  1  extend flag from the sequencer; sampled on an accepted fetch_start.
- index_load  in  1  one-cycle pulse: arm an index modification of the next fetched word.
- index_val  in  WORD_W  index value; sampled when index_load=1.
- mem_addr  out  ADDR_W  fetch address.
- mem_rd  out  1  fetch request level.
- mem_rdata  in  WORD_W  fetched word; valid when mem_ack=1.
- mem_ack  in  1  fetch complete.
- opcode  out  3  decoded instruction bits 14:12.
- qc  out  2  decoded instruction bits 11:10.
- operand_addr  out  ADDR_W  decoded instruction bits 11:0.
- extracode  out  1  extend flag bound to this instruction.
- instr_valid  out  1  decoded fields valid.
- instr_taken  in  1  sequencer accepts the decoded instruction.
- busy  out  1  high in any state other than IDLE.
- fetch_err  out  1  one-cycle pulse when a fetch times out.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - All outputs, the IR, the index pending flag, the index register and the timeout counter go to 0.
  - Reset overrides any operation in progress; an outstanding memory request is dropped (mem_rd=0 immediately).
- States: IDLE, FETCH, MODIFY, VALID.
- IDLE:
  - A fetch_start is accepted only in IDLE. On acceptance: mem_addr<=pc, extracode<=ext_flag, mem_rd<=1, timeout counter<=0, go to FETCH.
  - fetch_start in any other state is ignored.
- FETCH:
  - mem_rd is held at 1 until the cycle after mem_ack.
  - On mem_ack=1: IR<=mem_rdata, mem_rd<=0. Go to MODIFY if index pending, else VALID.
  - If the counter reaches ACK_TIMEOUT with no ack: mem_rd<=0, fetch_err pulses for 1 cycle, extracode<=0, go to IDLE. The index pending flag is kept.
- MODIFY (1 cycle):
  - IR[14:0] <= ones'-complement sum of IR[14:0] and index[14:0], with end-around carry: if the 15-bit add carries out, add 1.
  - IR[15] is unchanged. Clear the index pending flag. Go to VALID.
- VALID:
  - instr_valid=1. opcode, qc and operand_addr are driven from the IR and held stable until taken.
  - On instr_taken=1: instr_valid<=0, go to IDLE.
  - instr_taken outside VALID is ignored.
- Index arming:
  - index_load in any state sets the pending flag and captures index_val.
  - A second index_load before use overwrites the captured value.
  - index_load arriving in the same cycle as an accepted fetch_start, or at any time before the ack, modifies that fetch.
  - index_load arriving in MODIFY or VALID arms the next fetch.
  - index_load in the same cycle as the ack is applied to this fetch.
- Latency:
  - fetch_start at cycle 0 gives mem_rd=1 from cycle 1.
  - mem_ack at cycle k gives instr_valid at cycle k+1 without index, k+2 with index.
- busy is combinational from the state.
- fetch_err is never asserted together with instr_valid.

Test Plan:
- Plain fetch: pc=12'h123, ext_flag=0, mem returns 16'h5403 with ack 2 cycles after mem_rd -> mem_addr=12'h123; instr_valid one cycle after ack; opcode=5, qc=1, operand_addr=12'h403, extracode=0.
- Extracode binding: ext_flag=1 at fetch_start, then deasserted, word 16'h6010 -> opcode=6, extracode=1 held until instr_taken.
- Index with end-around carry: index_val=16'h0001, then fetch word 16'h7FFF -> IR[14:0]=15'h0001 (7FFF+1 carries out, plus 1); valid at ack+2; pending flag cleared, so next fetch unmodified.
- Timeout: ACK_TIMEOUT=15, never ack -> mem_rd drops and fetch_err pulses exactly once at count 15; state IDLE; a new fetch_start is then accepted.
- Handshake hold: no instr_taken for 10 cycles, then fetch_start during VALID -> fields stable and fetch_start ignored; instr_taken -> IDLE the next cycle.
- Reset mid-fetch: rst_n low while mem_rd=1 -> mem_rd, instr_valid and busy go to 0 asynchronously; a later ack is ignored.

Source files
------------

// File: rtl/instr_fetch_decode_if.sv
// Memory fetch bus between the instruction front end (master) and instruction memory (slave).
interface instr_fetch_decode_if #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (output mem_addr, mem_rd, input  mem_rdata, mem_ack);
  modport slave  (input  mem_addr, mem_rd, output mem_rdata, mem_ack);
endinterface

// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode front end: fetches the word at pc, applies an armed INDEX
// modification (ones'-complement add), and offers the decoded fields under valid/taken.
module instr_fetch_decode #(
  parameter int WORD_W      = 16,
  parameter int ADDR_W      = 12,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     pc,
  input  logic                  fetch_start,
  input  logic                  ext_flag,
  input  logic                  index_load,
  input  logic [WORD_W-1:0]     index_val,
  instr_fetch_decode_if.master  mem,
  output logic [2:0]            opcode,
  output logic [1:0]            qc,
  output logic [ADDR_W-1:0]     operand_addr,
  output logic                  extracode,
  output logic                  instr_valid,
  input  logic                  instr_taken,
  output logic                  busy,
  output logic                  fetch_err
);
  localparam int DW = WORD_W - 1;  // data bits; the top bit is parity

  typedef enum logic [1:0] {IDLE, FETCH, MODIFY, VALID} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] ir;
  logic [DW-1:0]     idx_q;
  logic              idx_pend;
  logic [7:0]        cnt;
  logic              timeout_hit;
  logic              to_modify;
  logic [DW:0]       raw_sum;
  logic [DW-1:0]     oc_sum;
  logic              parity_unused;

  assign timeout_hit = (cnt + 8'd1) == 8'(ACK_TIMEOUT);
  // An index_load coinciding with the ack still belongs to this fetch.
  assign to_modify   = idx_pend | index_load;

  // Ones'-complement add: the carry out of the data field wraps back into bit 0.
  assign raw_sum = {1'b0, ir[DW-1:0]} + {1'b0, idx_q};
  assign oc_sum  = raw_sum[DW-1:0] + {{(DW-1){1'b0}}, raw_sum[DW]};

  assign opcode        = ir[DW-1 -: 3];
  assign qc            = ir[DW-4 -: 2];
  assign operand_addr  = ir[ADDR_W-1:0];
  assign busy          = (state_q != IDLE);
  assign parity_unused = ir[WORD_W-1] ^ index_val[WORD_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (fetch_start) state_d = FETCH;
      FETCH: begin
        if (mem.mem_ack)      state_d = to_modify ? MODIFY : VALID;
        else if (timeout_hit) state_d = IDLE;
      end
      MODIFY: state_d = VALID;
      VALID:  if (instr_taken) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem.mem_addr <= '0;
      mem.mem_rd   <= 1'b0;
      extracode    <= 1'b0;
      instr_valid  <= 1'b0;
      fetch_err    <= 1'b0;
      ir           <= '0;
      idx_q        <= '0;
      idx_pend     <= 1'b0;
      cnt          <= '0;
    end else begin
      fetch_err <= 1'b0;
      if (index_load) begin
        idx_pend <= 1'b1;
        idx_q    <= index_val[DW-1:0];
      end
      unique case (state_q)
        IDLE: if (fetch_start) begin
          mem.mem_addr <= pc;
          extracode    <= ext_flag;
          mem.mem_rd   <= 1'b1;
          cnt          <= '0;
        end
        FETCH: begin
          if (mem.mem_ack) begin
            ir         <= mem.mem_rdata;
            mem.mem_rd <= 1'b0;
            if (!to_modify) instr_valid <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
            if (timeout_hit) begin
              mem.mem_rd <= 1'b0;
              fetch_err  <= 1'b1;
              extracode  <= 1'b0;
            end
          end
        end
        MODIFY: begin
          ir[DW-1:0]  <= oc_sum;
          instr_valid <= 1'b1;
          // A load landing here arms the following fetch instead.
          idx_pend    <= index_load;
        end
        VALID: if (instr_taken) instr_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: directed scenarios plus randomized fetches against a word-level model.
module tb_instr_fetch_decode;
  localparam int WORD_W = 16, ADDR_W = 12, ACK_TIMEOUT = 15;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [ADDR_W-1:0] pc = '0;
  logic fetch_start = 0, ext_flag = 0, index_load = 0, instr_taken = 0;
  logic [WORD_W-1:0] index_val = '0;
  logic [2:0] opcode;
  logic [1:0] qc;
  logic [ADDR_W-1:0] operand_addr;
  logic extracode, instr_valid, busy, fetch_err;

  int checks = 0, errors = 0;
  bit m_pend = 0;
  logic [15:0] m_idx = '0;

  always #5 clk = ~clk;

  instr_fetch_decode_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) mem ();

  instr_fetch_decode #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .fetch_start(fetch_start), .ext_flag(ext_flag),
    .index_load(index_load), .index_val(index_val), .mem(mem.master), .opcode(opcode), .qc(qc),
    .operand_addr(operand_addr), .extracode(extracode), .instr_valid(instr_valid),
    .instr_taken(instr_taken), .busy(busy), .fetch_err(fetch_err));

  // Word the sequencer should see: data field plus index in ones'-complement arithmetic.
  function automatic logic [15:0] ref_word(input logic [15:0] w, input bit pend, input logic [15:0] idx);
    int s;
    if (!pend) return w;
    s = int'(w[14:0]) + int'(idx[14:0]);
    if (s > 32767) s = s - 32767;
    return {w[15], 15'(s)};
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Drives one fetch; ack comes lat cycles after mem_rd first rises. idx_when: 0 none,
  // 1 with fetch_start, 2 with ack, 3 once valid. Returns cycles from ack to instr_valid.
  task automatic run_fetch(input logic [11:0] a, input bit ext, input logic [15:0] w, input int lat,
                           input int idx_when, input logic [15:0] iv,
                           output logic [11:0] o_addr, output logic o_rd, output int o_delay);
    fetch_start = 1; pc = a; ext_flag = ext;
    if (idx_when == 1) begin index_load = 1; index_val = iv; end
    tick;
    fetch_start = 0; index_load = 0; ext_flag = 1'($urandom); pc = 12'($urandom);
    o_addr = mem.mem_addr; o_rd = mem.mem_rd;
    repeat (lat) tick;
    mem.mem_ack = 1; mem.mem_rdata = w;
    if (idx_when == 2) begin index_load = 1; index_val = iv; end
    tick;
    mem.mem_ack = 0; mem.mem_rdata = 16'($urandom); index_load = 0;
    o_delay = 1;
    while (!instr_valid && o_delay < 6) begin tick; o_delay++; end
    if (!instr_valid) o_delay = 99;
    if (idx_when == 3) begin index_load = 1; index_val = iv; tick; index_load = 0; end
  endtask

  task automatic take;
    instr_taken = 1; tick; instr_taken = 0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (mem.mem_rd !== 1'b0 || instr_valid !== 1'b0 || busy !== 1'b0 || fetch_err !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got rd=%b v=%b busy=%b err=%b, expected all 0", mem.mem_rd, instr_valid, busy, fetch_err); end
    checks++; if (mem.mem_addr !== 12'h0 || opcode !== 3'd0 || qc !== 2'd0 || operand_addr !== 12'h0 || extracode !== 1'b0) begin
      errors++; $display("FAIL reset_data: got addr=%h op=%h qc=%h opnd=%h x=%b, expected 0", mem.mem_addr, opcode, qc, operand_addr, extracode); end
    tick; rst_n = 1; tick;
  endtask

  task automatic test_plain_fetch;
    logic [11:0] a; logic rd; int d;
    run_fetch(12'h123, 1'b0, 16'h5403, 2, 0, 16'h0, a, rd, d);
    checks++; if (a !== 12'h123) begin errors++; $display("FAIL plain_addr: got %h expected 123", a); end
    checks++; if (rd !== 1'b1) begin errors++; $display("FAIL plain_rd: got %b expected 1", rd); end
    checks++; if (d != 1) begin errors++; $display("FAIL plain_latency: got %0d expected 1", d); end
    checks++; if (opcode !== 3'd5 || qc !== 2'd1 || operand_addr !== 12'h403 || extracode !== 1'b0) begin
      errors++; $display("FAIL plain_fields: got op=%h qc=%h opnd=%h x=%b expected 5 1 403 0", opcode, qc, operand_addr, extracode); end
    take;
    checks++; if (instr_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL plain_take: got v=%b busy=%b expected 0 0", instr_valid, busy); end
  endtask

  task automatic test_extracode;
    logic [11:0] a; logic rd; int d; int bad = 0;
    run_fetch(12'h0A0, 1'b1, 16'h6010, 1, 0, 16'h0, a, rd, d);
    ext_flag = 0;
    for (int i = 0; i < 4; i++) begin
      if (opcode !== 3'd6 || extracode !== 1'b1 || instr_valid !== 1'b1) bad++;
      tick;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL extracode_hold: got %0d bad cycles (x=%b op=%h) expected 0", bad, extracode, opcode); end
    take;
  endtask

  task automatic test_index_carry;
    logic [11:0] a; logic rd; int d;
    index_load = 1; index_val = 16'h0001; tick; index_load = 0; tick;
    run_fetch(12'h200, 1'b0, 16'h7FFF, 3, 0, 16'h0, a, rd, d);
    checks++; if (d != 2) begin errors++; $display("FAIL index_latency: got %0d expected 2", d); end
    checks++; if (opcode !== 3'd0 || qc !== 2'd0 || operand_addr !== 12'h001) begin
      errors++; $display("FAIL index_eac: got op=%h qc=%h opnd=%h expected 0 0 001", opcode, qc, operand_addr); end
    take;
    run_fetch(12'h201, 1'b0, 16'h7FFF, 0, 0, 16'h0, a, rd, d);
    checks++; if (d != 1 || operand_addr !== 12'hFFF || opcode !== 3'd7) begin
      errors++; $display("FAIL index_cleared: got lat=%0d opnd=%h op=%h expected 1 fff 7", d, operand_addr, opcode); end
    take;
  endtask

  task automatic test_timeout;
    logic [11:0] a; logic rd; int d; int rd_cnt = 0, err_cnt = 0, both = 0, err_cyc = -1;
    fetch_start = 1; pc = 12'h345; ext_flag = 1; index_load = 1; index_val = 16'h0002;
    tick;
    fetch_start = 0; ext_flag = 0; index_load = 0;
    for (int i = 1; i <= 25; i++) begin
      if (mem.mem_rd) rd_cnt++;
      if (fetch_err) begin err_cnt++; err_cyc = i; end
      if (fetch_err && instr_valid) both++;
      if (i == 8) begin fetch_start = 1; pc = 12'hFFF; end
      if (i == 9) fetch_start = 0;
      tick;
    end
    checks++; if (rd_cnt != ACK_TIMEOUT) begin errors++; $display("FAIL timeout_rd_cycles: got %0d expected %0d", rd_cnt, ACK_TIMEOUT); end
    checks++; if (err_cnt != 1 || err_cyc != ACK_TIMEOUT + 1) begin
      errors++; $display("FAIL timeout_err_pulse: got %0d pulses at %0d expected 1 at %0d", err_cnt, err_cyc, ACK_TIMEOUT + 1); end
    checks++; if (both != 0 || busy !== 1'b0 || extracode !== 1'b0 || mem.mem_addr !== 12'h345) begin
      errors++; $display("FAIL timeout_idle: got both=%0d busy=%b x=%b addr=%h expected 0 0 0 345", both, busy, extracode, mem.mem_addr); end
    // Pending index survives the abort and applies to the retried fetch.
    run_fetch(12'h346, 1'b0, 16'h1005, 1, 0, 16'h0, a, rd, d);
    checks++; if (a !== 12'h346 || d != 2 || opcode !== 3'd1 || operand_addr !== 12'h007) begin
      errors++; $display("FAIL timeout_refetch: got addr=%h lat=%0d op=%h opnd=%h expected 346 2 1 007", a, d, opcode, operand_addr); end
    take;
  endtask

  task automatic test_handshake_hold;
    logic [11:0] a; logic rd; int d; int bad = 0;
    run_fetch(12'h3AB, 1'b1, 16'h2C55, 2, 0, 16'h0, a, rd, d);
    for (int i = 0; i < 10; i++) begin
      fetch_start = (i == 4); pc = 12'h777;
      if (instr_valid !== 1'b1 || opcode !== 3'd2 || qc !== 2'd3 || operand_addr !== 12'hC55 ||
          extracode !== 1'b1 || mem.mem_rd !== 1'b0 || mem.mem_addr !== 12'h3AB) bad++;
      tick;
    end
    fetch_start = 0;
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable: got %0d bad cycles expected 0", bad); end
    take;
    checks++; if (instr_valid !== 1'b0 || busy !== 1'b0 || mem.mem_rd !== 1'b0) begin
      errors++; $display("FAIL hold_take: got v=%b busy=%b rd=%b expected 0 0 0", instr_valid, busy, mem.mem_rd); end
  endtask

  task automatic test_reset_mid_fetch;
    int bad = 0;
    fetch_start = 1; pc = 12'h0F0; tick; fetch_start = 0; tick;
    checks++; if (mem.mem_rd !== 1'b1) begin errors++; $display("FAIL rst_pre_rd: got %b expected 1", mem.mem_rd); end
    rst_n = 0; #1;
    checks++; if (mem.mem_rd !== 1'b0 || instr_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_async: got rd=%b v=%b busy=%b expected 0 0 0", mem.mem_rd, instr_valid, busy); end
    tick; rst_n = 1; tick;
    mem.mem_ack = 1; mem.mem_rdata = 16'h1234; tick; mem.mem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      if (instr_valid !== 1'b0 || busy !== 1'b0) bad++;
      tick;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_late_ack: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_random;
    logic [11:0] a, ra; logic rd; int d, lat, iw, hold; bit ext, exp_pend;
    logic [15:0] w, iv, exp_idx, ew;
    m_pend = 0;
    for (int n = 0; n < 24; n++) begin
      ra = 12'($urandom); ext = 1'($urandom); w = 16'($urandom); iv = 16'($urandom);
      lat = $urandom_range(0, 5); iw = $urandom_range(0, 3); hold = $urandom_range(0, 3);
      exp_pend = m_pend || iw == 1 || iw == 2;
      exp_idx  = (iw == 1 || iw == 2) ? iv : m_idx;
      ew = ref_word(w, exp_pend, exp_idx);
      run_fetch(ra, ext, w, lat, iw, iv, a, rd, d);
      checks++; if (a !== ra || rd !== 1'b1) begin errors++; $display("FAIL rand_addr[%0d]: got %h rd=%b expected %h 1", n, a, rd, ra); end
      checks++; if (d != (exp_pend ? 2 : 1)) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, d, exp_pend ? 2 : 1); end
      checks++; if (opcode !== ew[14:12] || qc !== ew[11:10] || operand_addr !== ew[11:0] || extracode !== ext) begin
        errors++; $display("FAIL rand_fields[%0d]: got op=%h qc=%h opnd=%h x=%b expected %h %h %h %b",
                           n, opcode, qc, operand_addr, extracode, ew[14:12], ew[11:10], ew[11:0], ext); end
      m_pend = (iw == 3);
      m_idx  = (iw == 3) ? iv : exp_idx;
      repeat (hold) tick;
      take;
      checks++; if (instr_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rand_take[%0d]: got v=%b busy=%b expected 0 0", n, instr_valid, busy); end
    end
  endtask

  initial begin
    mem.mem_ack = 0; mem.mem_rdata = '0;
    test_reset;
    test_plain_fetch;
    test_extracode;
    test_index_carry;
    test_timeout;
    test_handshake_hold;
    test_reset_mid_fetch;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
